// File: rtl/ysyx_041461_pipe_ctrl_pkg.sv
// Shared definitions for the ysyx_041461 pipeline controller.
// Holds the controller FSM state encodings, the PC redirect-select codes and
// the per-stage handshake helpers that the stage valid slices and the top
// both use, so that ready/advance are computed the same way everywhere.
package ysyx_041461_pipe_ctrl_pkg;

  // Controller FSM states, visible on ctrl_state.
  typedef enum logic [1:0] {
    ysyx_041461_PCTRL_RUN   = 2'd0,
    ysyx_041461_PCTRL_DRAIN = 2'd1,
    ysyx_041461_PCTRL_REDIR = 2'd2
  } pctrl_state_t;

  // pc_redirect_sel codes.
  localparam logic YSYX_041461_REDIR_BRANCH = 1'b0;
  localparam logic YSYX_041461_REDIR_TRAP   = 1'b1;

  // A stage can take a new instruction when it is empty, or when its current
  // occupant is not held and the next stage can take it.
  function automatic logic stage_ready(input logic valid, input logic hold,
                                       input logic ready_next);
    return (~valid) | ((~hold) & ready_next);
  endfunction

  // A stage hands its instruction forward this cycle.
  function automatic logic stage_adv(input logic valid, input logic hold,
                                     input logic ready_next);
    return valid & (~hold) & ready_next;
  endfunction

endpackage

// File: rtl/ysyx_041461_stage_vld.sv
// One pipeline stage valid slice (used for IF2..WB).
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   flush       - clear the valid bit next cycle (trap, drain, branch kill)
//   adv_prev    - the previous stage hands an instruction forward this cycle
//   hold        - this stage's hazard hold
//   ready_next  - the next stage can accept this cycle
//   valid       - registered valid bit of this stage
//   ready       - this stage can accept an instruction this cycle
module ysyx_041461_stage_vld
  import ysyx_041461_pipe_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic adv_prev,
  input  logic hold,
  input  logic ready_next,
  output logic valid,
  output logic ready
);

  logic valid_r;

  assign ready = stage_ready(valid_r, hold, ready_next);
  assign valid = valid_r;

  // Valid bit: load on incoming advance, go empty (bubble) when this stage
  // drains forward with nothing arriving, otherwise keep the stalled occupant.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
    end else if (flush) begin
      valid_r <= 1'b0;
    end else if (adv_prev) begin
      valid_r <= 1'b1;
    end else if (ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

endmodule

// File: rtl/ysyx_041461_pipe_ctrl.sv
// Six-stage pipeline controller (IF, IF2, ID, EXE, MEM, WB).
// Tracks stage valids with backpressure, issues load enables, handles taken
// branches from ID (same-cycle redirect) and traps from WB (flush, wait for
// the outstanding fetch to drain, then redirect to the trap target).
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   if_fetch_valid, if_busy       - IF holds an instruction / fetch outstanding
//   id/exe/mem_conflict, mem_busy - per-stage hazard holds
//   id_br_taken, wb_trap          - taken branch in ID / trap in WB
//   *_valid, *_en                 - stage valids and register load enables
//   if_accept, if_kill            - IF handshake and fetch kill
//   pc_redirect, pc_redirect_sel  - redirect pulse and source (0 br, 1 trap)
//   trap_commit                   - WB trap is committing this cycle
//   ctrl_state, stall_cnt         - FSM state and saturating stall counter
module ysyx_041461_pipe_ctrl
  import ysyx_041461_pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_fetch_valid,
  input  logic             if_busy,
  input  logic             id_conflict,
  input  logic             exe_conflict,
  input  logic             mem_conflict,
  input  logic             mem_busy,
  input  logic             id_br_taken,
  input  logic             wb_trap,
  output logic             if2_valid,
  output logic             id_valid,
  output logic             exe_valid,
  output logic             mem_valid,
  output logic             wb_valid,
  output logic             if2_en,
  output logic             id_en,
  output logic             exe_en,
  output logic             mem_en,
  output logic             wb_en,
  output logic             if_accept,
  output logic             if_kill,
  output logic             pc_redirect,
  output logic             pc_redirect_sel,
  output logic             trap_commit,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  pctrl_state_t     state_r;
  logic [CNT_W-1:0] stall_cnt_r;

  logic ready_if2_s, ready_id_s, ready_exe_s, ready_mem_s, ready_wb_s;
  logic adv_if_s, adv_if2_s, adv_id_s, adv_exe_s, adv_mem_s;
  logic hold_mem_s, stall_any_s;
  logic flush_all_s, br_kill_s, flush_if2_s;

  assign hold_mem_s = mem_conflict | mem_busy;

  assign adv_if_s  = stage_adv(if_fetch_valid, if_busy, ready_if2_s);
  assign adv_if2_s = stage_adv(if2_valid, 1'b0, ready_id_s);
  assign adv_id_s  = stage_adv(id_valid, id_conflict, ready_exe_s);
  assign adv_exe_s = stage_adv(exe_valid, exe_conflict, ready_mem_s);
  assign adv_mem_s = stage_adv(mem_valid, hold_mem_s, ready_wb_s);

  assign flush_if2_s = flush_all_s | br_kill_s;

  ysyx_041461_stage_vld u_if2 (.clk(clk), .rst(rst), .flush(flush_if2_s),
    .adv_prev(adv_if_s),  .hold(1'b0),         .ready_next(ready_id_s),
    .valid(if2_valid), .ready(ready_if2_s));
  ysyx_041461_stage_vld u_id  (.clk(clk), .rst(rst), .flush(flush_all_s),
    .adv_prev(adv_if2_s), .hold(id_conflict),  .ready_next(ready_exe_s),
    .valid(id_valid),  .ready(ready_id_s));
  ysyx_041461_stage_vld u_exe (.clk(clk), .rst(rst), .flush(flush_all_s),
    .adv_prev(adv_id_s),  .hold(exe_conflict), .ready_next(ready_mem_s),
    .valid(exe_valid), .ready(ready_exe_s));
  ysyx_041461_stage_vld u_mem (.clk(clk), .rst(rst), .flush(flush_all_s),
    .adv_prev(adv_exe_s), .hold(hold_mem_s),   .ready_next(ready_wb_s),
    .valid(mem_valid), .ready(ready_mem_s));
  ysyx_041461_stage_vld u_wb  (.clk(clk), .rst(rst), .flush(flush_all_s),
    .adv_prev(adv_mem_s), .hold(1'b0),         .ready_next(1'b1),
    .valid(wb_valid),  .ready(ready_wb_s));

  assign if2_en = ready_if2_s;
  assign id_en  = ready_id_s;
  assign exe_en = ready_exe_s;
  assign mem_en = ready_mem_s;
  assign wb_en  = ready_wb_s;

  assign trap_commit = wb_valid & wb_trap;
  assign ctrl_state  = state_r;
  assign stall_cnt   = stall_cnt_r;

  // IF2 never holds, so only IF, ID, EXE and MEM can be the stalled stage.
  assign stall_any_s = (if_fetch_valid & if_busy) | (id_valid & id_conflict) |
                       (exe_valid & exe_conflict) | (mem_valid & hold_mem_s);

  // Redirect/kill decode; a committing trap takes priority over an ID branch.
  always_comb begin
    flush_all_s     = 1'b0;
    br_kill_s       = 1'b0;
    if_accept       = 1'b0;
    if_kill         = 1'b0;
    pc_redirect     = 1'b0;
    pc_redirect_sel = YSYX_041461_REDIR_BRANCH;
    case (state_r)
      ysyx_041461_PCTRL_RUN: begin
        if (trap_commit) begin
          flush_all_s = 1'b1;
          if_kill     = 1'b1;
        end else if (adv_id_s & id_br_taken) begin
          br_kill_s   = 1'b1;
          if_kill     = 1'b1;
          pc_redirect = 1'b1;
        end else begin
          if_accept = adv_if_s;
        end
      end
      ysyx_041461_PCTRL_DRAIN: begin
        flush_all_s = 1'b1;
        if_kill     = 1'b1;
      end
      ysyx_041461_PCTRL_REDIR: begin
        flush_all_s     = 1'b1;
        pc_redirect     = 1'b1;
        pc_redirect_sel = YSYX_041461_REDIR_TRAP;
      end
      default: begin
        flush_all_s = 1'b1;
        if_kill     = 1'b1;
      end
    endcase
  end

  // Controller FSM: trap -> wait for outstanding fetch -> one-cycle redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ysyx_041461_PCTRL_RUN;
    end else begin
      case (state_r)
        ysyx_041461_PCTRL_RUN: begin
          if (trap_commit) begin
            state_r <= if_busy ? ysyx_041461_PCTRL_DRAIN : ysyx_041461_PCTRL_REDIR;
          end else begin
            state_r <= ysyx_041461_PCTRL_RUN;
          end
        end
        ysyx_041461_PCTRL_DRAIN: begin
          state_r <= if_busy ? ysyx_041461_PCTRL_DRAIN : ysyx_041461_PCTRL_REDIR;
        end
        ysyx_041461_PCTRL_REDIR: state_r <= ysyx_041461_PCTRL_RUN;
        default:                 state_r <= ysyx_041461_PCTRL_RUN;
      endcase
    end
  end

  // Saturating count of RUN cycles in which some occupied stage is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if ((state_r == ysyx_041461_PCTRL_RUN) && stall_any_s &&
                 (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + CNT_ONE;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

endmodule

// File: tb/tb_ysyx_041461_pipe_ctrl.sv
// Directed bench for ysyx_041461_pipe_ctrl. A 3-bit stall counter is used so
// saturation (7) is reachable with a short stall sequence.
module tb_ysyx_041461_pipe_ctrl;

  localparam int CNT_W = 3;

  logic clk = 1'b0;
  logic rst, if_fetch_valid, if_busy, id_conflict, exe_conflict, mem_conflict;
  logic mem_busy, id_br_taken, wb_trap;
  logic if2_valid, id_valid, exe_valid, mem_valid, wb_valid;
  logic if2_en, id_en, exe_en, mem_en, wb_en;
  logic if_accept, if_kill, pc_redirect, pc_redirect_sel, trap_commit;
  logic [1:0] ctrl_state;
  logic [CNT_W-1:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  ysyx_041461_pipe_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .if_fetch_valid(if_fetch_valid), .if_busy(if_busy),
    .id_conflict(id_conflict), .exe_conflict(exe_conflict),
    .mem_conflict(mem_conflict), .mem_busy(mem_busy),
    .id_br_taken(id_br_taken), .wb_trap(wb_trap),
    .if2_valid(if2_valid), .id_valid(id_valid), .exe_valid(exe_valid),
    .mem_valid(mem_valid), .wb_valid(wb_valid),
    .if2_en(if2_en), .id_en(id_en), .exe_en(exe_en), .mem_en(mem_en),
    .wb_en(wb_en), .if_accept(if_accept), .if_kill(if_kill),
    .pc_redirect(pc_redirect), .pc_redirect_sel(pc_redirect_sel),
    .trap_commit(trap_commit), .ctrl_state(ctrl_state), .stall_cnt(stall_cnt));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] valids();
    return {if2_valid, id_valid, exe_valid, mem_valid, wb_valid};
  endfunction

  function automatic logic [4:0] ens();
    return {if2_en, id_en, exe_en, mem_en, wb_en};
  endfunction

  initial begin
    rst = 1'b1; if_fetch_valid = 1'b0; if_busy = 1'b0; id_conflict = 1'b0;
    exe_conflict = 1'b0; mem_conflict = 1'b0; mem_busy = 1'b0;
    id_br_taken = 1'b0; wb_trap = 1'b0;
    step(); step();
    rst = 1'b0; #1;
    chk("rst_state", 32'(ctrl_state), 32'd0);
    chk("rst_valids", 32'(valids()), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_redirect", 32'(pc_redirect), 32'd0);

    // Free flow: accepted now, reaches WB after five edges.
    if_fetch_valid = 1'b1; #1;
    chk("flow_accept", 32'(if_accept), 32'd1);
    chk("flow_if2_en", 32'(if2_en), 32'd1);
    step();
    chk("flow_if2", 32'(if2_valid), 32'd1);
    step(); step(); step();
    chk("flow_4cyc", 32'(valids()), 32'b11110);
    step();
    chk("flow_5cyc", 32'(valids()), 32'b11111);
    chk("flow_stall", 32'(stall_cnt), 32'd0);

    // EXE hazard for three cycles: upstream frozen, bubble into MEM.
    exe_conflict = 1'b1; #1;
    chk("exe_accept", 32'(if_accept), 32'd0);
    chk("exe_ens", 32'(ens()), 32'b00011);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("exe_mem_bubble", 32'(mem_valid), 32'd0);
      chk("exe_frozen", 32'({if2_valid, id_valid, exe_valid}), 32'b111);
    end
    exe_conflict = 1'b0; #1;
    chk("exe_stall_cnt", 32'(stall_cnt), 32'd3);
    step();
    chk("exe_release", 32'({mem_valid, wb_valid}), 32'b10);

    // MEM busy for five cycles: counter runs 3 -> 8 and saturates at 7.
    mem_busy = 1'b1; #1;
    chk("mem_ens", 32'(ens()), 32'b00001);
    for (int i = 0; i < 5; i++) step();
    chk("mem_stall_sat", 32'(stall_cnt), 32'd7);
    chk("mem_hold", 32'({mem_valid, wb_valid}), 32'b10);
    mem_busy = 1'b0;
    step();
    chk("mem_release", 32'(valids()), 32'b11111);

    // Taken branch in ID: same-cycle redirect, IF2 killed next cycle.
    id_br_taken = 1'b1; #1;
    chk("br_redirect", 32'({pc_redirect, pc_redirect_sel}), 32'b10);
    chk("br_kill", 32'({if_kill, if_accept}), 32'b10);
    step();
    id_br_taken = 1'b0; #1;
    chk("br_if2_id", 32'({if2_valid, id_valid}), 32'b01);
    chk("br_after", 32'({if_accept, if_kill, pc_redirect}), 32'b100);

    // Trap and branch together, fetch outstanding: trap path only.
    wb_trap = 1'b1; id_br_taken = 1'b1; if_busy = 1'b1; #1;
    chk("trap_commit", 32'(trap_commit), 32'd1);
    chk("trap_no_br", 32'(pc_redirect), 32'd0);
    chk("trap_kill", 32'({if_kill, if_accept}), 32'b10);
    step();
    wb_trap = 1'b0; id_br_taken = 1'b0; #1;
    chk("drain1_state", 32'(ctrl_state), 32'd1);
    chk("drain1_valids", 32'(valids()), 32'd0);
    chk("drain1_ctl", 32'({trap_commit, pc_redirect, if_kill, if_accept}), 32'b0010);
    chk("drain_stall", 32'(stall_cnt), 32'd7);
    step();
    chk("drain2_state", 32'(ctrl_state), 32'd1);
    chk("drain2_valids", 32'(valids()), 32'd0);
    if_busy = 1'b0; #1;
    chk("drain2_redirect", 32'(pc_redirect), 32'd0);
    step();
    chk("redir_state", 32'(ctrl_state), 32'd2);
    chk("redir_pulse", 32'({pc_redirect, pc_redirect_sel}), 32'b11);
    chk("redir_valids", 32'(valids()), 32'd0);
    chk("redir_accept", 32'(if_accept), 32'd0);
    step();
    chk("run_state", 32'(ctrl_state), 32'd0);
    chk("run_redirect", 32'(pc_redirect), 32'd0);
    chk("run_valids", 32'(valids()), 32'd0);

    // Refill, trap into DRAIN, then reset in the middle of it.
    for (int i = 0; i < 5; i++) step();
    chk("refill_wb", 32'(wb_valid), 32'd1);
    wb_trap = 1'b1; if_busy = 1'b1;
    step();
    wb_trap = 1'b0; #1;
    chk("rst_drain_state", 32'(ctrl_state), 32'd1);
    rst = 1'b1; #1;
    chk("rst_drain_noredir", 32'(pc_redirect), 32'd0);
    step();
    rst = 1'b0; if_busy = 1'b0; if_fetch_valid = 1'b0; #1;
    chk("rst2_state", 32'(ctrl_state), 32'd0);
    chk("rst2_valids", 32'(valids()), 32'd0);
    chk("rst2_stall", 32'(stall_cnt), 32'd0);
    chk("rst2_redirect", 32'(pc_redirect), 32'd0);
    step();
    chk("rst2_stay_run", 32'({ctrl_state, pc_redirect}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_041461_pipe_ctrl.md
YSYX_041461_PIPE_CTRL -- requirements
Module: ysyx_041461_pipe_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, stall-counter width.
REQ-002 SHALL have ports: clk in 1 clock; rst in 1 reset, synchronous, active-high.
REQ-003 SHALL have ports: if_fetch_valid in 1 (IF holds a fetched instr); if_busy in 1 (IF fetch outstanding); id_conflict, exe_conflict, mem_conflict in 1 each (hazard holds from conflict detector); mem_busy in 1 (MEM access not done); id_br_taken in 1 (ID instr is a taken branch/jump); wb_trap in 1 (WB instr carries a trap).
REQ-004 SHALL have ports: if2_valid, id_valid, exe_valid, mem_valid, wb_valid out 1 each (stage valid registers); if2_en, id_en, exe_en, mem_en, wb_en out 1 each (pipeline-register load enables); if_accept out 1; if_kill out 1; pc_redirect out 1; pc_redirect_sel out 1 (0 branch, 1 trap); trap_commit out 1; ctrl_state out 2; stall_cnt out CNT_W.

Function
REQ-005 SHALL define stage order IF, IF2, ID, EXE, MEM, WB; hold_IF=if_busy, hold_IF2=0, hold_ID=id_conflict, hold_EXE=exe_conflict, hold_MEM=mem_conflict|mem_busy, hold_WB=0.
REQ-006 SHALL compute ready_WB=1; ready_s = !v_s | (!hold_s & ready_{s+1}), with v_IF=if_fetch_valid.
REQ-007 SHALL define adv_s = v_s & !hold_s & ready_{s+1}; <next>_en = ready_{next}; if_accept = adv_IF in RUN.
REQ-008 SHALL update v_{s+1} each cycle: 1 if adv_s; else 0 if ready_{s+1}; else hold (bubble insertion on stall).
REQ-009 SHALL assert trap_commit when wb_valid & wb_trap, in any state, that cycle.
REQ-010 SHALL implement FSM states RUN=0, DRAIN=1, REDIR=2 on ctrl_state.
REQ-011 RUN, trap_commit: clear v_IF2..v_WB next cycle, if_accept=0, if_kill=1; next DRAIN if if_busy else REDIR.
REQ-012 RUN, no trap, adv_ID & id_br_taken: pc_redirect=1, sel=0, if_kill=1, if_accept=0 same cycle; v_IF2 next=0; ID advances normally.
REQ-013 Trap and branch in the same cycle: trap wins; no branch redirect.
REQ-014 DRAIN: all valids held 0, if_accept=0, if_kill=1; transition to REDIR when if_busy=0.
REQ-015 REDIR: pc_redirect=1, sel=1 for exactly one cycle, valids 0, if_accept=0; next RUN.
REQ-016 SHALL keep pc_redirect=0 except the conditions in REQ-012/015.
REQ-017 stall_cnt SHALL increment by 1 each RUN cycle where any v_s & hold_s (s in IF..MEM); saturate at all-ones, no wrap.
REQ-018 All outputs combinational from registered state and current inputs; redirect latency 0 cycles from decision; trap-to-redirect latency = 1 + DRAIN cycles.

Reset
REQ-019 On rst: all stage valids 0, ctrl_state RUN, stall_cnt 0; rst dominates all other inputs in the same cycle.
REQ-020 Reset during DRAIN or REDIR SHALL return to RUN with no redirect pulse.

Structure
REQ-021 FSM state encodings (ysyx_041461_PCTRL_RUN/DRAIN/REDIR) and redirect-select codes SHALL reside in the shared ysyx_041461 defines file.
REQ-022 One sub-module ysyx_041461_stage_vld (valid bit + ready/adv logic) SHALL be instantiated once per stage IF2..WB.
REQ-023 No latches; single always-ff block per register group.

Verification
REQ-024 Free flow: if_fetch_valid=1 constantly, no holds -> first instr reaches wb_valid 5 cycles after acceptance; stall_cnt stays 0.
REQ-025 exe_conflict=1 for 3 cycles with all stages full -> IF..EXE frozen, mem_valid=0 bubble for 3 cycles, stall_cnt=3.
REQ-026 id_br_taken with ID advancing -> same cycle pc_redirect=1, sel=0, if_kill=1; next cycle if2_valid=0.
REQ-027 wb_trap with wb_valid, if_busy=1 for 2 more cycles -> trap_commit 1 cycle, DRAIN 2 cycles, REDIR 1 cycle with sel=1, RUN; all valids 0 throughout.
REQ-028 wb_trap and id_br_taken same cycle -> only trap path; no sel=0 redirect.
REQ-029 rst asserted mid-DRAIN -> next cycle ctrl_state=0, valids 0, stall_cnt 0; stall_cnt preloaded near max saturates at 2^CNT_W-1.
